vid_timing_gen_multi: RTL
=========================

Name: vid_timing_gen_multi

Overview:
- Parametrised video timing generator producing hsync/vsync/de and pixel/line coordinates for the HDMI TX path.
- Successor to the fixed single-mode timing configuration: two compile-time timing sets (mode 0 / mode 1) with runtime switching that only takes effect at frame boundaries.
- Sits between the pixel-clock domain and the pixel pipeline feeding the HDMI encoder.

Parameters:
- H_BITS, 12, width of horizontal counter and timing fields
- V_BITS, 11, width of vertical counter and timing fields
- M0_H_ACTIVE/M0_H_FP/M0_H_SYNC/M0_H_BP, 1920/88/44/148, mode 0 horizontal timing
- M0_V_ACTIVE/M0_V_FP/M0_V_SYNC/M0_V_BP, 1080/4/5/36, mode 0 vertical timing
- M1_H_ACTIVE/M1_H_FP/M1_H_SYNC/M1_H_BP, 1280/110/40/220, mode 1 horizontal timing
- M1_V_ACTIVE/M1_V_FP/M1_V_SYNC/M1_V_BP, 720/5/5/20, mode 1 vertical timing
- SYNC_POL, 1'b1, active level of hsync/vsync

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run generator; deassert stops at next frame end
- mode_req  in  1  requested mode (0/1)
- mode_cur  out  1  mode currently being generated
- mode_busy  out  1  high while mode_req != mode_cur and change pending
- hsync  out  1  horizontal sync, polarity SYNC_POL
- vsync  out  1  vertical sync, polarity SYNC_POL
- de  out  1  active video
- hcount  out  H_BITS  pixel x within line
- vcount  out  V_BITS  line y within frame
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
- line_start  out  1  one-cycle pulse at hcount=0 of every line

Behaviour:
- One clock domain; reset is synchronous, active-low (rst_n sampled on rising clk).
- Reset values: hsync=vsync=~SYNC_POL, de=0, hcount=0, vcount=0, frame_start=0, line_start=0, mode_cur=0, mode_busy=0, FSM=ST_IDLE.
- FSM: ST_IDLE -> ST_RUN when enable=1; latches mode_cur<=mode_req on that transition; counters start at 0 next cycle.
- ST_RUN: hcnt increments 0..H_TOTAL-1, wraps to 0 and increments vcnt; vcnt wraps 0 after V_TOTAL-1. H_TOTAL/V_TOTAL = sum of the four fields of mode_cur, computed at elaboration, width H_BITS/V_BITS (elaboration error if total exceeds 2^BITS).
- At frame end (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1): if enable=0 -> ST_IDLE; else if mode_req!=mode_cur -> ST_SWITCH; else wrap.
- ST_SWITCH: exactly one cycle, all outputs inactive, mode_cur<=mode_req, then ST_RUN from 0,0.
- Outputs registered, 1-cycle latency from internal counters: de = hcnt<H_ACTIVE && vcnt<V_ACTIVE; hsync active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync active for whole lines vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- hcount/vcount mirror the counters (same latency as de).
- mode_busy = (mode_req!=mode_cur) in ST_RUN; 0 in ST_IDLE.
- mode_req toggling mid-frame: only the value at frame end is used; toggling back before frame end causes no switch.
- rst_n low mid-frame: all outputs return to reset values the next cycle.

Optional Feature:
- VTG_FRAME_CNT_EN defined: adds output frame_cnt [15:0], incremented on each frame_start, wraps at 65535->0, reset 0, cleared on mode switch.
- Not defined: port absent, no counter logic.

Decomposition:
- Package vid_timing_pkg: state enum (ST_IDLE, ST_RUN, ST_SWITCH), typedef struct vid_mode_t {h_active,h_fp,h_sync,h_bp,v_active,v_fp,v_sync,v_bp}, function total_h/total_v.
- No sub-module; a single counter/compare module is sufficient.

Test Plan:
- Reset, enable=1, mode_req=0 -> first frame_start 2 cycles after enable; line period 2200 clocks, frame 2200*1125 clocks, de high 1920 consecutive clocks per line for 1080 lines.
- Mode 0 line -> hsync active exactly for hcount 2008..2051 (44 clocks); vsync active for lines 1084..1088.
- mode_req 0->1 at vcount=500 -> mode_busy=1 until frame end, one idle cycle, then 1650-clock lines, 750-line frames, mode_cur=1.
- mode_req pulse 0->1->0 within one frame -> no ST_SWITCH, mode_cur stays 0, line period unchanged.
- enable dropped mid-frame -> frame completes, then de=0, hsync/vsync inactive, hcount=vcount=0 held.
- rst_n low at hcount=1000 -> next cycle all outputs reset values; with VTG_FRAME_CNT_EN, frame_cnt=3 after 3 frames then 0 after reset.

Source files
------------

// File: rtl/vid_timing_gen_multi_pkg.sv
// Shared types for the two-mode video timing generator: FSM states, the
// timing-set record and helpers that sum a set into line/frame totals.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } vtg_state_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vid_mode_t;

  function automatic int unsigned total_h(input vid_mode_t m);
    return m.h_active + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic int unsigned total_v(input vid_mode_t m);
    return m.v_active + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/vid_timing_gen_multi_if.sv
// Control and video-timing bundle between the timing generator (master)
// and the pixel pipeline (slave). frame_cnt exists only with VTG_FRAME_CNT_EN.
interface vid_timing_gen_multi_if #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 11
);
  logic              enable;
  logic              mode_req;
  logic              mode_cur;
  logic              mode_busy;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [H_BITS-1:0] hcount;
  logic [V_BITS-1:0] vcount;
  logic              frame_start;
  logic              line_start;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]       frame_cnt;

  modport master (input enable, mode_req,
                  output mode_cur, mode_busy, hsync, vsync, de, hcount, vcount,
                  frame_start, line_start, frame_cnt);
  modport slave  (output enable, mode_req,
                  input mode_cur, mode_busy, hsync, vsync, de, hcount, vcount,
                  frame_start, line_start, frame_cnt);
`else
  modport master (input enable, mode_req,
                  output mode_cur, mode_busy, hsync, vsync, de, hcount, vcount,
                  frame_start, line_start);
  modport slave  (output enable, mode_req,
                  input mode_cur, mode_busy, hsync, vsync, de, hcount, vcount,
                  frame_start, line_start);
`endif
endinterface

// File: rtl/vid_timing_gen_multi.sv
// Two-mode video timing generator; mode changes are applied only at frame end.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vid_timing_gen_multi
  import vid_timing_pkg::*;
#(
  parameter int   H_BITS      = 12,
  parameter int   V_BITS      = 11,
  parameter int   M0_H_ACTIVE = 1920,
  parameter int   M0_H_FP     = 88,
  parameter int   M0_H_SYNC   = 44,
  parameter int   M0_H_BP     = 148,
  parameter int   M0_V_ACTIVE = 1080,
  parameter int   M0_V_FP     = 4,
  parameter int   M0_V_SYNC   = 5,
  parameter int   M0_V_BP     = 36,
  parameter int   M1_H_ACTIVE = 1280,
  parameter int   M1_H_FP     = 110,
  parameter int   M1_H_SYNC   = 40,
  parameter int   M1_H_BP     = 220,
  parameter int   M1_V_ACTIVE = 720,
  parameter int   M1_V_FP     = 5,
  parameter int   M1_V_SYNC   = 5,
  parameter int   M1_V_BP     = 20,
  parameter logic SYNC_POL    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vid_timing_gen_multi_if.master vif
);

  localparam vid_mode_t MODE0 = '{h_active: M0_H_ACTIVE, h_fp: M0_H_FP, h_sync: M0_H_SYNC,
                                  h_bp: M0_H_BP, v_active: M0_V_ACTIVE, v_fp: M0_V_FP,
                                  v_sync: M0_V_SYNC, v_bp: M0_V_BP};
  localparam vid_mode_t MODE1 = '{h_active: M1_H_ACTIVE, h_fp: M1_H_FP, h_sync: M1_H_SYNC,
                                  h_bp: M1_H_BP, v_active: M1_V_ACTIVE, v_fp: M1_V_FP,
                                  v_sync: M1_V_SYNC, v_bp: M1_V_BP};

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_SWITCH = ST_SWITCH;

  if (total_h(MODE0) > (32'd1 << H_BITS) || total_h(MODE1) > (32'd1 << H_BITS) ||
      total_v(MODE0) > (32'd1 << V_BITS) || total_v(MODE1) > (32'd1 << V_BITS)) begin : g_bad_cfg
    $error("vid_timing_gen_multi: timing total exceeds counter width");
  end

  function automatic logic in_win(input int unsigned v, input int unsigned lo,
                                  input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

  logic [1:0]        state_p0;
  logic              mode_p0;
  logic [H_BITS-1:0] hcnt_p0;
  logic [V_BITS-1:0] vcnt_p0;
  logic              de_p1, hs_p1, vs_p1, fs_p1, ls_p1;
  logic [H_BITS-1:0] hcount_p1;
  logic [V_BITS-1:0] vcount_p1;

  vid_mode_t   cfg;
  int unsigned hx, vx;
  logic        h_end, v_end, frame_top;

  assign cfg       = mode_p0 ? MODE1 : MODE0;
  assign hx        = 32'(hcnt_p0);
  assign vx        = 32'(vcnt_p0);
  assign h_end     = (hx == total_h(cfg) - 1);
  assign v_end     = (vx == total_v(cfg) - 1);
  assign frame_top = (hcnt_p0 == '0) && (vcnt_p0 == '0);

  // p0: control FSM and raster counters; p1: registered video outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0  <= S_IDLE;
      mode_p0   <= 1'b0;
      hcnt_p0   <= '0;
      vcnt_p0   <= '0;
      de_p1     <= 1'b0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      fs_p1     <= 1'b0;
      ls_p1     <= 1'b0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
    end else begin
      de_p1     <= 1'b0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      fs_p1     <= 1'b0;
      ls_p1     <= 1'b0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      case (state_p0)
        S_IDLE: begin
          if (vif.enable) begin
            state_p0 <= S_RUN;
            mode_p0  <= vif.mode_req;
            hcnt_p0  <= '0;
            vcnt_p0  <= '0;
          end
        end
        S_RUN: begin
          de_p1     <= (hx < cfg.h_active) && (vx < cfg.v_active);
          hs_p1     <= in_win(hx, cfg.h_active + cfg.h_fp, cfg.h_sync) ? SYNC_POL : ~SYNC_POL;
          vs_p1     <= in_win(vx, cfg.v_active + cfg.v_fp, cfg.v_sync) ? SYNC_POL : ~SYNC_POL;
          fs_p1     <= frame_top;
          ls_p1     <= (hcnt_p0 == '0);
          hcount_p1 <= hcnt_p0;
          vcount_p1 <= vcnt_p0;
          if (!h_end) begin
            hcnt_p0 <= hcnt_p0 + H_BITS'(1);
          end else begin
            hcnt_p0 <= '0;
            if (!v_end) begin
              vcnt_p0 <= vcnt_p0 + V_BITS'(1);
            end else begin
              vcnt_p0 <= '0;
              // mode_req is only sampled here, so mid-frame glitches are ignored
              if (!vif.enable)                  state_p0 <= S_IDLE;
              else if (vif.mode_req != mode_p0) state_p0 <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          mode_p0  <= vif.mode_req;
          state_p0 <= S_RUN;
          hcnt_p0  <= '0;
          vcnt_p0  <= '0;
        end
        default: state_p0 <= S_IDLE;
      endcase
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)                                 frame_cnt_p1 <= '0;
    else if (state_p0 == S_SWITCH)              frame_cnt_p1 <= '0;
    else if (state_p0 == S_RUN && frame_top)    frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
  end

  assign vif.frame_cnt = frame_cnt_p1;
`endif

  assign vif.mode_cur    = mode_p0;
  assign vif.mode_busy   = (state_p0 != S_IDLE) && (vif.mode_req != mode_p0);
  assign vif.hsync       = hs_p1;
  assign vif.vsync       = vs_p1;
  assign vif.de          = de_p1;
  assign vif.hcount      = hcount_p1;
  assign vif.vcount      = vcount_p1;
  assign vif.frame_start = fs_p1;
  assign vif.line_start  = ls_p1;

endmodule
